// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the raw bus, decodes 11-bit frames,
// and queues scancodes in a FIFO read through a single memory-mapped status/data word.
module ps2_rx #(
  parameter int FIFO_DEPTH     = 16,
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        ren,
  output logic [15:0] data,
  output logic        avail
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int FLT_W = $clog2(FILTER_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Synchronizers and glitch filter
  logic             clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic             filt_q, filt_d;
  logic [FLT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic             sample_evt, sample_bit;

  // Frame decoder
  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_ok_q, parity_ok_d;
  logic [TO_W-1:0]  timeout_q, timeout_d;
  logic             push_req;

  // FIFO and read port
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      data_q, data_d;
  logic             avail_q, avail_d;
  logic             nonempty, full, push, pop;

  always_comb begin
    filt_cnt_d = '0;
    filt_d     = filt_q;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FLT_W'(FILTER_CYCLES - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FLT_W'(1);
      end
    end
    sample_evt = filt_q & ~filt_d;
    sample_bit = data_s2_q;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_ok_d = parity_ok_q;
    timeout_d   = timeout_q;
    push_req    = 1'b0;
    if (sample_evt) begin
      timeout_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!sample_bit) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shift_d[bit_cnt_q] = sample_bit;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        S_PARITY: begin
          parity_ok_d = (^shift_q) ^ sample_bit;
          state_d     = S_STOP;
        end
        default: begin
          push_req = sample_bit & parity_ok_q;
          state_d  = S_IDLE;
        end
      endcase
    end else if (state_q == S_IDLE) begin
      timeout_d = '0;
    end else if (timeout_q >= TO_W'(TIMEOUT_CYCLES - 1)) begin
      // A stalled keyboard mid-frame: abandon the partial byte
      state_d   = S_IDLE;
      timeout_d = '0;
    end else begin
      timeout_d = timeout_q + TO_W'(1);
    end
  end

  always_comb begin
    nonempty = (count_q != '0);
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    pop      = ren & nonempty;
    push     = push_req & (~full | pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    // A drop in the same cycle as a read keeps the flag: the dropped code is newer than the read
    overflow_d = overflow_q;
    if (push_req && !push) begin
      overflow_d = 1'b1;
    end else if (ren) begin
      overflow_d = 1'b0;
    end
    data_d = data_q;
    if (ren) begin
      data_d = nonempty ? {6'b0, overflow_q, 1'b1, mem[rd_ptr_q]} : {6'b0, overflow_q, 9'b0};
    end
    avail_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      data_s1_q   <= 1'b1;
      data_s2_q   <= 1'b1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_ok_q <= 1'b0;
      timeout_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      data_q      <= 16'h0000;
      avail_q     <= 1'b0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      data_s1_q   <= ps2_data;
      data_s2_q   <= data_s1_q;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_ok_q <= parity_ok_d;
      timeout_q   <= timeout_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      data_q      <= data_d;
      avail_q     <= avail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= shift_q;
    end
  end

  assign data  = data_q;
  assign avail = avail_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: directed PS/2 frames, expected read words queued at each read strobe
// and checked by an independent monitor on the cycle the word becomes visible.
module tb_ps2_rx;

  localparam int FIFO_DEPTH     = 16;
  localparam int FILTER_CYCLES  = 8;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HALF           = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        ren = 1'b0;
  logic [15:0] data;
  logic        avail;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q [$];
  logic        ren_dly = 1'b0;

  ps2_rx #(
    .FIFO_DEPTH    (FIFO_DEPTH),
    .FILTER_CYCLES (FILTER_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .ren     (ren),
    .data    (data),
    .avail   (avail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ren_dly <= ren & ~rst;

  always @(negedge clk) begin
    if (ren_dly) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL read_word: got %h with no expected word queued", data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (data !== e) begin
          miscompares++;
          $display("FAIL read_word: got %h expected %h", data, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_parity);
    logic par;
    par = ~(^code) ^ bad_parity;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(par);
    send_bit(1'b1);
    ps2_data = 1'b1;
    cyc(HALF + 10);
  endtask

  task automatic read_word(input logic [15:0] e);
    exp_q.push_back(e);
    ren = 1'b1;
    cyc(1);
    ren = 1'b0;
    cyc(1);
  endtask

  initial begin
    // Reset held while the bus and read strobe wiggle
    ren = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ps2_clk  = i[0];
      ps2_data = i[1];
      cyc(1);
      check("reset_data", data, 16'h0000);
      check("reset_avail", {15'b0, avail}, 16'h0000);
    end
    ren = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(5);

    // Valid frame 0x1C
    send_frame(8'h1C, 1'b0);
    check("avail_after_1c", {15'b0, avail}, 16'h0001);
    read_word(16'h011C);
    check("avail_after_read", {15'b0, avail}, 16'h0000);

    // Bad parity is discarded
    send_frame(8'h1C, 1'b1);
    check("avail_bad_parity", {15'b0, avail}, 16'h0000);
    read_word(16'h0000);

    // Overflow: 17 frames into a 16-entry FIFO
    for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b0);
    check("avail_full", {15'b0, avail}, 16'h0001);
    read_word(16'h0301);
    for (int i = 2; i <= 16; i++) read_word(16'h0100 | 16'(i));
    check("avail_drained", {15'b0, avail}, 16'h0000);
    read_word(16'h0000);

    // Partial frame abandoned by timeout
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_data = 1'b1;
    cyc(TIMEOUT_CYCLES + 10);
    send_frame(8'h5A, 1'b0);
    read_word(16'h015A);
    read_word(16'h0000);

    // Short low glitch on ps2_clk while data is low must not start a frame
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    cyc(FILTER_CYCLES - 2);
    ps2_clk  = 1'b1;
    cyc(HALF);
    ps2_data = 1'b1;
    cyc(HALF);
    send_frame(8'h22, 1'b0);
    read_word(16'h0122);
    read_word(16'h0000);

    // Reset mid-frame discards the partial frame
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    ps2_data = 1'b1;
    rst = 1'b1;
    cyc(3);
    check("midframe_reset_avail", {15'b0, avail}, 16'h0000);
    rst = 1'b0;
    cyc(5);
    send_frame(8'h76, 1'b0);
    read_word(16'h0176);
    read_word(16'h0000);
    check("avail_end", {15'b0, avail}, 16'h0000);

    cyc(2);
    check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, number of scancode entries buffered; power of two, 2..256.
REQ-002 SHALL have parameter FILTER_CYCLES, default 8, consecutive equal samples needed to accept a new ps2_clk level.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, idle clk cycles mid-frame before the frame is abandoned.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 ps2_clk  input  1  raw keyboard clock, asynchronous to clk.
REQ-007 ps2_data  input  1  raw keyboard data, asynchronous to clk.
REQ-008 ren  input  1  read strobe from memory block, high when a load targets 0xFFFF.
REQ-009 data  output  16  read word; drives memory block's ps2_data_in.
REQ-010 avail  output  1  high while FIFO non-empty.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-012 Filtered clock level SHALL change only after synced ps2_clk holds the new value FILTER_CYCLES consecutive cycles.
REQ-013 A falling edge (filtered 1->0) SHALL be a one-cycle sample event; synced ps2_data at that cycle is the sampled bit.
REQ-014 Receive FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: sample 0 -> DATA with bit counter 0; sample 1 -> stay IDLE (no push).
REQ-016 DATA: shift sample into bit (counter) of shift register, LSB first; after 8th sample -> PARITY.
REQ-017 PARITY: store parity_ok = (XOR of 8 data bits XOR sample) == 1 (odd parity); -> STOP.
REQ-018 STOP: sample 1 and parity_ok -> push scancode; otherwise discard; either way -> IDLE.
REQ-019 Timeout counter SHALL reset on every sample event and in IDLE; reaching TIMEOUT_CYCLES outside IDLE -> IDLE, partial frame discarded.
REQ-020 Push to full FIFO with no same-cycle pop SHALL drop the scancode and set sticky overflow flag.
REQ-021 On a rising clk edge with ren=1: FIFO non-empty -> data <= {6'b0, overflow, 1'b1, head}, head popped, overflow cleared; empty -> data <= {6'b0, overflow, 9'b0}, overflow cleared.
REQ-022 data SHALL hold its value when ren=0, so the word is stable the cycle after the strobe, when the memory block samples it.
REQ-023 Same-cycle push and pop: non-empty -> both performed, count unchanged; full -> push accepted (no overflow); empty -> pop returns empty word, push stored.
REQ-024 Overflow set and cleared in the same cycle SHALL leave overflow set, and the returned word shows the pre-edge value.
REQ-025 FIFO SHALL be circular; read/write pointers wrap modulo FIFO_DEPTH; count register 0..FIFO_DEPTH separates full from empty.
REQ-026 avail SHALL be registered, equal to (count != 0) after each edge.
REQ-027 Scancodes SHALL be returned in arrival order with no duplication or loss except REQ-020 drops.

Reset
REQ-028 rst=1 at a clk edge SHALL set: FSM IDLE, bit counter 0, timeout 0, FIFO pointers and count 0, overflow 0, data 16'h0000, avail 0.
REQ-029 Synchronizer and filter flops SHALL reset to 1 (bus idle level).
REQ-030 Reset mid-frame SHALL discard the partial frame; the next sample event is treated as from IDLE.
REQ-031 Outputs SHALL remain at reset values while rst is held, regardless of ps2_clk, ps2_data, ren.

Verification
REQ-032 Frame 0x1C (start 0, bits 00111000 LSB first, parity 0, stop 1), then ren pulse -> data=16'h011C next cycle; avail 1 -> 0.
REQ-033 Frame 0x1C with parity 1 -> no push; avail stays 0; ren -> data=16'h0000.
REQ-034 17 valid frames 0x01..0x11 with no reads (FIFO_DEPTH 16) -> first read 16'h0301, following reads 0x0102..0x0110 then 16'h0000; 0x11 never returned.
REQ-035 Start bit plus 4 data bits, then TIMEOUT_CYCLES+10 idle cycles, then full frame 0x5A -> only 0x5A returned (16'h015A).
REQ-036 ps2_clk low glitch of FILTER_CYCLES-2 cycles during IDLE with ps2_data=0 -> FSM stays IDLE; subsequent frame 0x22 decodes correctly.
REQ-037 rst asserted after 5 data bits, released, then frame 0x76 -> read returns 16'h0176, nothing else queued.
